// File: rtl/core_run_monitor.sv
// Run-control monitor: halt-event/timeout capture, post-halt drain window, retire counter and
// optional writeback trace buffer (enabled by defining CORE_RUN_MONITOR_TRACE_EN).
module core_run_monitor #(
  parameter int unsigned N_EVT        = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned TIMEOUT      = 100,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_EVT-1:0]           i_evt_pulse,
  input  logic [31:0]                i_halt_pc_in,
  input  logic                       i_wb_wen,
  input  logic [4:0]                 i_wb_rd,
  input  logic [31:0]                i_wb_data,
  input  logic [$clog2(DEPTH)-1:0]   i_trc_idx,
  output logic                       o_done,
  output logic                       o_halted,
  output logic                       o_timed_out,
  output logic [$clog2(N_EVT)-1:0]   o_halt_cause,
  output logic [31:0]                o_halt_pc,
  output logic [CNT_W-1:0]           o_cycles,
  output logic [CNT_W-1:0]           o_retired,
  output logic [$clog2(DEPTH):0]     o_trc_count,
  output logic [36:0]                o_trc_rdata
);

  localparam int unsigned EVT_W = $clog2(N_EVT);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e             r_state;
  logic               r_done;
  logic               r_halted;
  logic               r_timed_out;
  logic [EVT_W-1:0]   r_halt_cause;
  logic [31:0]        r_halt_pc;
  logic [CNT_W-1:0]   r_cycles;
  logic [CNT_W-1:0]   r_retired;
  logic [CNT_W-1:0]   r_drain_cnt;

  logic               w_evt_any;
  logic               w_timeout;
  logic               w_wb_qual;
  logic [EVT_W-1:0]   w_evt_idx;

  // Scan downward so the lowest set index is the last one assigned.
  always_comb begin
    w_evt_idx = '0;
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (i_evt_pulse[i]) w_evt_idx = EVT_W'(i);
    end
  end

  assign w_evt_any = |i_evt_pulse;
  assign w_timeout = (r_cycles == CNT_W'(TIMEOUT - 1));
  assign w_wb_qual = i_wb_wen && (i_wb_rd != 5'd0) && (r_state != StDone);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StRun;
      r_done       <= 1'b0;
      r_halted     <= 1'b0;
      r_timed_out  <= 1'b0;
      r_halt_cause <= '0;
      r_halt_pc    <= '0;
      r_cycles     <= '0;
      r_retired    <= '0;
      r_drain_cnt  <= '0;
    end else begin
      if (w_wb_qual) r_retired <= r_retired + CNT_W'(1);
      unique case (r_state)
        StRun: begin
          r_cycles <= r_cycles + CNT_W'(1);
          if (w_evt_any || w_timeout) begin
            r_halted    <= 1'b1;
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
            if (w_evt_any) begin
              r_halt_cause <= w_evt_idx;
              r_halt_pc    <= i_halt_pc_in;
            end else begin
              r_timed_out <= 1'b1;
            end
            if (DRAIN_CYCLES == 0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          r_drain_cnt <= r_drain_cnt - CNT_W'(1);
          if (r_drain_cnt == CNT_W'(1)) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign o_done       = r_done;
  assign o_halted     = r_halted;
  assign o_timed_out  = r_timed_out;
  assign o_halt_cause = r_halt_cause;
  assign o_halt_pc    = r_halt_pc;
  assign o_cycles     = r_cycles;
  assign o_retired    = r_retired;

`ifdef CORE_RUN_MONITOR_TRACE_EN
  localparam logic [PTR_W:0] TRC_FULL = (PTR_W + 1)'(DEPTH);

  logic [36:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_trc_count;
  logic [36:0]      r_trc_rdata;
  logic [PTR_W-1:0] w_rd_addr;

  // Index 0 maps to the oldest valid entry; truncation gives the mod-DEPTH wrap.
  assign w_rd_addr = r_wr_ptr - r_trc_count[PTR_W-1:0] + i_trc_idx;

  always_ff @(posedge i_clk) begin
    if (w_wb_qual) r_mem[r_wr_ptr] <= {i_wb_rd, i_wb_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_trc_count <= '0;
      r_trc_rdata <= '0;
    end else begin
      if (w_wb_qual) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (r_trc_count != TRC_FULL) r_trc_count <= r_trc_count + (PTR_W + 1)'(1);
      end
      r_trc_rdata <= ({1'b0, i_trc_idx} < r_trc_count) ? r_mem[w_rd_addr] : '0;
    end
  end

  assign o_trc_count = r_trc_count;
  assign o_trc_rdata = r_trc_rdata;
`else
  logic w_unused_trace;
  assign w_unused_trace = ^{i_trc_idx, i_wb_data};
  assign o_trc_count    = '0;
  assign o_trc_rdata    = '0;
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor: directed scenarios with randomized writeback traffic,
// checked every edge against an edge-count based reference model.
module tb_core_run_monitor;
  localparam int unsigned N_EVT   = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned DRAIN   = 4;
  localparam int unsigned DEPTH   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  evt;
  logic [31:0] pc_in;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [3:0]  tidx;

  logic        done, halted, timed_out, cause;
  logic [31:0] hpc, cycles, retired;
  logic [4:0]  tcnt;
  logic [36:0] trdata;

  logic        z_done, z_halted, z_timed_out, z_cause;
  logic [31:0] z_hpc, z_cycles, z_retired;
  logic [4:0]  z_tcnt;
  logic [36:0] z_trdata;

  core_run_monitor #(.N_EVT(N_EVT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN),
                     .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_evt_pulse(evt), .i_halt_pc_in(pc_in), .i_wb_wen(wen),
    .i_wb_rd(rd), .i_wb_data(wdata), .i_trc_idx(tidx), .o_done(done), .o_halted(halted),
    .o_timed_out(timed_out), .o_halt_cause(cause), .o_halt_pc(hpc), .o_cycles(cycles),
    .o_retired(retired), .o_trc_count(tcnt), .o_trc_rdata(trdata)
  );

  // Second instance with no drain window, sharing all inputs.
  core_run_monitor #(.N_EVT(N_EVT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DRAIN_CYCLES(0),
                     .DEPTH(DEPTH)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_evt_pulse(evt), .i_halt_pc_in(pc_in), .i_wb_wen(wen),
    .i_wb_rd(rd), .i_wb_data(wdata), .i_trc_idx(tidx), .o_done(z_done), .o_halted(z_halted),
    .o_timed_out(z_timed_out), .o_halt_cause(z_cause), .o_halt_pc(z_hpc), .o_cycles(z_cycles),
    .o_retired(z_retired), .o_trc_count(z_tcnt), .o_trc_rdata(z_trdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset release, halt edge, and the retained trace as a queue.
  int unsigned e;
  bit          m_halted;
  int unsigned m_hk;
  int unsigned m_cause;
  logic [31:0] m_pc;
  bit          m_timed;
  int unsigned m_ret;
  logic [36:0] q[$];
  logic [36:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    e = 0; m_halted = 0; m_hk = 0; m_cause = 0; m_pc = '0; m_timed = 0; m_ret = 0;
    q.delete();
    m_rdata = '0;
  endtask

  task automatic check_all();
    int unsigned exp_cyc;
    int unsigned exp_cnt;
    exp_cyc = m_halted ? m_hk : e;
`ifdef CORE_RUN_MONITOR_TRACE_EN
    exp_cnt = q.size();
`else
    exp_cnt = 0;
`endif
    chk("halted", halted, m_halted);
    chk("done", done, m_halted && (e >= m_hk + DRAIN));
    chk("timed_out", timed_out, m_timed);
    chk("halt_cause", cause, m_cause);
    chk("halt_pc", hpc, m_pc);
    chk("cycles", cycles, exp_cyc);
    chk("retired", retired, m_ret);
    chk("trc_count", tcnt, exp_cnt);
    chk("trc_rdata", trdata, m_rdata);
    chk("d0_done", z_done, m_halted);
    chk("d0_timed_out", z_timed_out, m_timed);
    chk("d0_cycles", z_cycles, exp_cyc);
    chk("d0_halt_pc", z_hpc, m_pc);
  endtask

  task automatic step();
    logic [36:0] rexp;
    rexp = '0;
`ifdef CORE_RUN_MONITOR_TRACE_EN
    if (int'(tidx) < q.size()) rexp = q[tidx];
`endif
    e++;
    if (wen && rd != 5'd0 && (!m_halted || e <= m_hk + DRAIN)) begin
      m_ret++;
      q.push_back({rd, wdata});
      if (q.size() > DEPTH) void'(q.pop_front());
    end
    if (!m_halted) begin
      if (evt != 2'b00) begin
        m_halted = 1; m_hk = e; m_cause = evt[0] ? 0 : 1; m_pc = pc_in;
      end else if (e == TIMEOUT) begin
        m_halted = 1; m_hk = e; m_timed = 1;
      end
    end
    @(posedge clk);
    #1;
    m_rdata = rexp;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; evt = '0; wen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic rand_wb();
    wen   = 1'($urandom_range(0, 1));
    rd    = 5'($urandom_range(0, 31));
    wdata = $urandom;
    tidx  = 4'($urandom_range(0, 15));
    pc_in = $urandom;
  endtask

  initial begin
    logic [36:0] t0, t15;
    rst = 1'b1; evt = '0; pc_in = '0; wen = 1'b0; rd = '0; wdata = '0; tidx = '0;

    do_reset();
    chk("rst_halted", halted, 0);
    chk("rst_cycles", cycles, 0);

    // ECALL on the 5th edge, then ignored pulses during drain and after done.
    repeat (4) begin rand_wb(); step(); end
    rand_wb(); evt = 2'b01; pc_in = 32'h40; step(); evt = '0;
    chk("ecall_halted", halted, 1);
    chk("ecall_cycles", cycles, 5);
    chk("ecall_cause", cause, 0);
    chk("ecall_pc", hpc, 32'h40);
    repeat (3) begin rand_wb(); evt = 2'($urandom_range(0, 3)); step(); end
    evt = '0;
    chk("ecall_done_early", done, 0);
    rand_wb(); step();
    chk("ecall_done", done, 1);
    chk("ecall_timed_out", timed_out, 0);
    repeat (4) begin rand_wb(); evt = 2'($urandom_range(0, 3)); step(); end
    evt = '0;

    // Reset in the middle of DRAIN.
    do_reset();
    rand_wb(); evt = 2'b10; step(); evt = '0;
    repeat (2) begin rand_wb(); step(); end
    do_reset();
    chk("mid_drain_halted", halted, 0);
    chk("mid_drain_retired", retired, 0);
    rand_wb(); step();
    chk("mid_drain_run", cycles, 1);

    // Event and timeout on the same edge.
    do_reset();
    repeat (99) begin rand_wb(); step(); end
    chk("prio_cycles_pre", cycles, 99);
    rand_wb(); evt = 2'b11; step(); evt = '0;
    chk("prio_cause", cause, 0);
    chk("prio_timed_out", timed_out, 0);
    chk("prio_cycles", cycles, 100);
    repeat (5) begin rand_wb(); step(); end

    // Budget exhaustion.
    do_reset();
    repeat (99) begin rand_wb(); step(); end
    chk("to_d0_done_pre", z_done, 0);
    rand_wb(); step();
    chk("to_d0_done", z_done, 1);
    chk("to_d0_timed_out", z_timed_out, 1);
    chk("to_cycles", cycles, 100);
    chk("to_halt_pc", hpc, 0);
    repeat (6) begin rand_wb(); step(); end
    chk("to_done", done, 1);

    // Trace wrap with an rd=0 write mixed in.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      wen = 1'b1; rd = 5'(i); wdata = 32'(i) * 32'h11; tidx = 4'($urandom_range(0, 15));
      step();
      if (i == 10) begin rd = 5'd0; wdata = 32'hdead; step(); end
    end
    wen = 1'b0;
`ifdef CORE_RUN_MONITOR_TRACE_EN
    t0 = {5'd5, 32'h55};
    t15 = {5'd20, 32'h154};
`else
    t0 = '0;
    t15 = '0;
`endif
    tidx = 4'd0; step();
    chk("wrap_idx0", trdata, t0);
    tidx = 4'd15; step();
    chk("wrap_idx15", trdata, t15);
    chk("wrap_retired", retired, 20);

    // Writebacks inside the drain window versus after done.
    do_reset();
    wen = 1'b0; evt = 2'b01; pc_in = 32'h80; step(); evt = '0;
    repeat (3) begin wen = 1'b1; rd = 5'($urandom_range(1, 31)); wdata = $urandom; step(); end
    wen = 1'b0; step();
    chk("drain_done", done, 1);
    repeat (2) begin
      wen = 1'b1; rd = 5'($urandom_range(1, 31)); wdata = $urandom; evt = 2'b10; step();
    end
    wen = 1'b0; evt = '0;
    chk("drain_retired", retired, 3);
    chk("drain_pc", hpc, 32'h80);

    // Randomized runs.
    repeat (6) begin
      do_reset();
      repeat (130) begin
        rand_wb();
        evt = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        step();
      end
      evt = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
